mixer_chan_sched: RTL and testbench

//  Time-shares one Mixer instance between NCH antenna ADC channels sampled simultaneously.
//  - Latches one ADC frame (NCH samples) and issues the samples to the Mixer one at a time.
//  - Collects each I/Q pair returned by the Mixer and presents it downstream, tagged with its channel.
//  - Flags frame overruns and Mixer timeouts.
//  - Sits between the ADC capture front end and the per-channel demod/filter stage.

---
 rtl/mixer_pkg.sv | 14 +
 rtl/mixer_chan_sched_if.sv | 45 ++++
 rtl/mixer_chan_sched.sv | 165 ++++++++++++++++
 tb/tb_mixer_chan_sched.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
// Shared types and defaults for the Mixer channel scheduler.
package mixer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_I,
        WAIT_Q,
        OUT
    } sched_state_e;

    localparam int MIX_TIMEOUT_DEF = 64;

endpackage

// File: rtl/mixer_chan_sched_if.sv
// Frame input, Mixer request/response and result stream of the channel scheduler.
interface mixer_chan_sched_if #(
    parameter int DW  = 12,
    parameter int NCH = 3
);
    localparam int CW = $clog2(NCH);

    logic [NCH*DW-1:0] frm_data_i;
    logic              frm_valid_i;
    logic [DW-1:0]     mix_data_o;
    logic              mix_valid_o;
    logic              mix_first_o;
    logic              mix_ready_o;
    logic [DW-1:0]     mix_data_i;
    logic              mix_valid_i;
    logic              mix_last_i;
    logic [DW-1:0]     out_i_o;
    logic [DW-1:0]     out_q_o;
    logic [CW-1:0]     out_ch_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              frame_done_o;
    logic              busy_o;
    logic              overrun_o;
    logic              timeout_o;
    logic              clr_i;

    // master = the scheduler, slave = the surrounding ADC / Mixer / demod environment
    modport master (
        input  frm_data_i, frm_valid_i, mix_data_i, mix_valid_i, mix_last_i,
               out_ready_i, clr_i,
        output mix_data_o, mix_valid_o, mix_first_o, mix_ready_o,
               out_i_o, out_q_o, out_ch_o, out_valid_o,
               frame_done_o, busy_o, overrun_o, timeout_o
    );

    modport slave (
        output frm_data_i, frm_valid_i, mix_data_i, mix_valid_i, mix_last_i,
               out_ready_i, clr_i,
        input  mix_data_o, mix_valid_o, mix_first_o, mix_ready_o,
               out_i_o, out_q_o, out_ch_o, out_valid_o,
               frame_done_o, busy_o, overrun_o, timeout_o
    );

endinterface

// File: rtl/mixer_chan_sched.sv
// Time-shares one Mixer across NCH simultaneously sampled ADC channels:
// latches a frame, feeds samples one by one, collects I/Q pairs tagged by channel.
module mixer_chan_sched
    import mixer_pkg::*;
#(
    parameter int DW      = 12,
    parameter int NCH     = 3,
    parameter int TIMEOUT = MIX_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mixer_chan_sched_if.master bus
);
    localparam int CW = $clog2(NCH);
    localparam int TW = $clog2(TIMEOUT + 1);

    sched_state_e      state_reg, state_next;
    logic [NCH*DW-1:0] frm_reg, frm_next;
    logic [CW-1:0]     ch_reg, ch_next;
    logic [TW-1:0]     tmo_cnt_reg, tmo_cnt_next;
    logic [DW-1:0]     i_reg, i_next;
    logic [DW-1:0]     q_reg, q_next;
    logic [DW-1:0]     mix_data_reg, mix_data_next;
    logic              mix_valid_reg, mix_valid_next;
    logic              mix_first_reg, mix_first_next;
    logic              done_reg, done_next;
    logic              overrun_reg, overrun_next;
    logic              timeout_reg, timeout_next;
    logic              timeout_set;
    logic              tmo_expired;

    logic [DW-1:0] frm_word [NCH];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_frm_word
            assign frm_word[gi] = frm_reg[gi*DW +: DW];
        end
    endgenerate

    assign tmo_expired = (tmo_cnt_reg == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            frm_reg       <= '0;
            ch_reg        <= '0;
            tmo_cnt_reg   <= '0;
            i_reg         <= '0;
            q_reg         <= '0;
            mix_data_reg  <= '0;
            mix_valid_reg <= 1'b0;
            mix_first_reg <= 1'b0;
            done_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            frm_reg       <= frm_next;
            ch_reg        <= ch_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            i_reg         <= i_next;
            q_reg         <= q_next;
            mix_data_reg  <= mix_data_next;
            mix_valid_reg <= mix_valid_next;
            mix_first_reg <= mix_first_next;
            done_reg      <= done_next;
            overrun_reg   <= overrun_next;
            timeout_reg   <= timeout_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        frm_next       = frm_reg;
        ch_next        = ch_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        i_next         = i_reg;
        q_next         = q_reg;
        mix_data_next  = mix_data_reg;
        mix_valid_next = 1'b0;
        mix_first_next = 1'b0;
        done_next      = 1'b0;
        timeout_set    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.frm_valid_i) begin
                    frm_next   = bus.frm_data_i;
                    ch_next    = '0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // Mixer request is registered so it lines up with the first WAIT_I cycle
                mix_data_next  = frm_word[ch_reg];
                mix_valid_next = 1'b1;
                mix_first_next = (ch_reg == '0);
                tmo_cnt_next   = '0;
                state_next     = WAIT_I;
            end
            WAIT_I: begin
                if (bus.mix_valid_i && !bus.mix_last_i) begin
                    i_next       = bus.mix_data_i;
                    tmo_cnt_next = '0;
                    state_next   = WAIT_Q;
                end else if (bus.mix_valid_i || tmo_expired) begin
                    // a Q word arriving before its I word is handled like a dead Mixer
                    timeout_set = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TW'(1);
                end
            end
            WAIT_Q: begin
                if (bus.mix_valid_i && bus.mix_last_i) begin
                    q_next     = bus.mix_data_i;
                    state_next = OUT;
                end else if (tmo_expired) begin
                    timeout_set = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TW'(1);
                end
            end
            OUT: begin
                if (bus.out_ready_i) begin
                    if (ch_reg == CW'(NCH - 1)) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ch_next    = ch_reg + CW'(1);
                        state_next = ISSUE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (timeout_set) begin
            state_next = IDLE;
        end

        // sticky flags: a set event in the same cycle as clr_i takes priority
        overrun_next = bus.clr_i ? 1'b0 : overrun_reg;
        timeout_next = bus.clr_i ? 1'b0 : timeout_reg;
        if (bus.frm_valid_i && (state_reg != IDLE)) begin
            overrun_next = 1'b1;
        end
        if (timeout_set) begin
            timeout_next = 1'b1;
        end
    end

    assign bus.mix_data_o   = mix_data_reg;
    assign bus.mix_valid_o  = mix_valid_reg;
    assign bus.mix_first_o  = mix_first_reg;
    assign bus.mix_ready_o  = (state_reg == WAIT_I) || (state_reg == WAIT_Q);
    assign bus.out_i_o      = i_reg;
    assign bus.out_q_o      = q_reg;
    assign bus.out_ch_o     = ch_reg;
    assign bus.out_valid_o  = (state_reg == OUT);
    assign bus.frame_done_o = done_reg;
    assign bus.busy_o       = (state_reg != IDLE);
    assign bus.overrun_o    = overrun_reg;
    assign bus.timeout_o    = timeout_reg;

endmodule

// File: tb/tb_mixer_chan_sched.sv
// Scoreboard bench for mixer_chan_sched with a behavioural Mixer that echoes I=x, Q=-x.
module tb_mixer_chan_sched;
    import mixer_pkg::*;

    localparam int DW      = 12;
    localparam int NCH     = 3;
    localparam int TIMEOUT = MIX_TIMEOUT_DEF;

    localparam int M_NORMAL = 0;
    localparam int M_MUTE   = 1;
    localparam int M_SWAP   = 2;
    localparam int M_GAPQ   = 3;

    typedef struct {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
        int            ch;
    } out_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          first;
        int            mode;
    } iss_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mixer_chan_sched_if #(.DW(DW), .NCH(NCH)) bus ();

    mixer_chan_sched #(.DW(DW), .NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int   tests     = 0;
    int   fails     = 0;
    int   done_cnt  = 0;
    int   exp_done  = 0;
    int   fixed_dly = 3;
    bit   rand_en   = 1'b0;
    logic ready_force = 1'b1;
    out_t exp_out[$];
    iss_t exp_issue[$];

    function automatic logic [DW-1:0] neg(input logic [DW-1:0] x);
        return DW'(0) - x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // downstream ready: forced by the directed tests or randomly throttled
    initial begin
        bus.out_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready_i = rand_en ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // result monitor / scoreboard
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            if (bus.frame_done_o === 1'b1) done_cnt++;
            if (rst === 1'b0 && bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
                $display("[TB] out ch=%0d i=%0d q=%0d", bus.out_ch_o,
                         $signed(bus.out_i_o), $signed(bus.out_q_o));
                if (exp_out.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = exp_out.pop_front();
                    chk("out_ch", 64'(bus.out_ch_o), 64'(e.ch));
                    chk("out_i", 64'(bus.out_i_o), 64'(e.i));
                    chk("out_q", 64'(bus.out_q_o), 64'(e.q));
                end
            end
        end
    end

    // behavioural Mixer
    initial begin
        iss_t          it;
        logic [DW-1:0] x;
        int            d, gap, n;
        bus.mix_valid_i = 1'b0;
        bus.mix_last_i  = 1'b0;
        bus.mix_data_i  = '0;
        forever begin
            @(negedge clk);
            if (bus.mix_valid_o === 1'b1) begin
                if (exp_issue.size() == 0) begin
                    chk("unexpected_issue", 1, 0);
                end else begin
                    it = exp_issue.pop_front();
                    x  = bus.mix_data_o;
                    chk("mix_data", 64'(x), 64'(it.d));
                    chk("mix_first", 64'(bus.mix_first_o), 64'(it.first));
                    d   = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 4));
                    gap = (it.mode == M_GAPQ) ? 10 : int'($urandom_range(0, 2));
                    case (it.mode)
                        M_MUTE: begin
                            n = 0;
                            while (bus.timeout_o !== 1'b1 && n < 4 * TIMEOUT) begin
                                @(negedge clk);
                                n++;
                            end
                            chk("timeout_latency", 64'(n), 64'(TIMEOUT));
                        end
                        M_SWAP: begin
                            repeat (d) @(posedge clk);
                            #1 bus.mix_data_i = neg(x); bus.mix_last_i = 1'b1; bus.mix_valid_i = 1'b1;
                            @(posedge clk);
                            #1 bus.mix_valid_i = 1'b0;
                        end
                        default: begin
                            repeat (d) @(posedge clk);
                            #1 bus.mix_data_i = x; bus.mix_last_i = 1'b0; bus.mix_valid_i = 1'b1;
                            chk("mix_ready", 64'(bus.mix_ready_o), 64'(1));
                            @(posedge clk);
                            #1 bus.mix_valid_i = 1'b0;
                            repeat (gap) @(posedge clk);
                            #1 bus.mix_data_i = neg(x); bus.mix_last_i = 1'b1; bus.mix_valid_i = 1'b1;
                            @(posedge clk);
                            #1 bus.mix_valid_i = 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // reference model: channels before a faulty one produce (x,-x,k); the faulty one is issued only
    task automatic send_frame(input logic [NCH*DW-1:0] frm, input int fault_ch, input int fault_mode);
        logic [DW-1:0] s;
        for (int k = 0; k < NCH; k++) begin
            s = frm[k*DW +: DW];
            if (fault_ch < 0 || k < fault_ch)
                exp_out.push_back('{i: s, q: neg(s), ch: k});
            if (fault_ch < 0 || k <= fault_ch)
                exp_issue.push_back('{d: s, first: (k == 0), mode: (k == fault_ch) ? fault_mode : M_NORMAL});
        end
        if (fault_ch < 0) exp_done++;
        @(posedge clk);
        #1 bus.frm_data_i = frm; bus.frm_valid_i = 1'b1;
        @(posedge clk);
        #1 bus.frm_valid_i = 1'b0;
    endtask

    task automatic pulse_frm(input logic [NCH*DW-1:0] frm, input logic with_clr);
        @(posedge clk);
        #1 bus.frm_data_i = frm; bus.frm_valid_i = 1'b1; bus.clr_i = with_clr;
        @(posedge clk);
        #1 bus.frm_valid_i = 1'b0; bus.clr_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy_o !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", 64'(bus.busy_o), 64'(0));
    endtask

    task automatic wait_out_valid();
        int n = 0;
        @(negedge clk);
        while (bus.out_valid_o !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("wait_out_valid", 64'(bus.out_valid_o), 64'(1));
    endtask

    task automatic end_frame(input logic exp_to, input logic exp_ov);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("outputs_drained", 64'(exp_out.size()), 64'(0));
        chk("issues_drained", 64'(exp_issue.size()), 64'(0));
        chk("frame_done_cnt", 64'(done_cnt), 64'(exp_done));
        chk("timeout_flag", 64'(bus.timeout_o), 64'(exp_to));
        chk("overrun_flag", 64'(bus.overrun_o), 64'(exp_ov));
        if (exp_to || exp_ov) begin
            bus.clr_i = 1'b1;
            @(posedge clk);
            #1 bus.clr_i = 1'b0;
            chk("flags_cleared", 64'({bus.timeout_o, bus.overrun_o}), 64'(0));
        end
    endtask

    function automatic logic [NCH*DW-1:0] mk3(input int a, input int b, input int c);
        logic [NCH*DW-1:0] f;
        f = '0;
        f[0*DW +: DW] = DW'(a);
        f[1*DW +: DW] = DW'(b);
        f[2*DW +: DW] = DW'(c);
        return f;
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({bus.busy_o, bus.out_valid_o, bus.mix_valid_o, bus.mix_first_o, bus.mix_ready_o,
                    bus.frame_done_o, bus.overrun_o, bus.timeout_o, bus.mix_data_o,
                    bus.out_i_o, bus.out_q_o, bus.out_ch_o});
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH*DW-1:0] f;
        logic [DW-1:0]     ci, cq;
        int                n;
        rst = 1'b1;
        bus.frm_data_i  = '0;
        bus.frm_valid_i = 1'b0;
        bus.clr_i       = 1'b0;
        repeat (3) @(posedge clk);
        #3 chk("reset_outputs", all_outs(), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // basic frame, fixed 3-cycle Mixer
        send_frame(mk3(100, -200, 300), -1, M_NORMAL);
        end_frame(1'b0, 1'b0);

        // backpressure: hold ch1 for 20 cycles
        ready_force = 1'b0;
        send_frame(mk3(7, -8, 9), -1, M_NORMAL);
        wait_out_valid();
        @(posedge clk);
        #1 ready_force = 1'b1;
        @(posedge clk);
        #1 ready_force = 1'b0;
        wait_out_valid();
        chk("bp_channel", 64'(bus.out_ch_o), 64'(1));
        ci = bus.out_i_o;
        cq = bus.out_q_o;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("bp_hold", 64'({bus.out_valid_o, bus.out_i_o, bus.out_q_o, bus.mix_valid_o, bus.mix_ready_o}),
                64'({1'b1, ci, cq, 1'b0, 1'b0}));
        end
        @(posedge clk);
        #1 ready_force = 1'b1;
        end_frame(1'b0, 1'b0);

        // overrun, then overrun and clr together (set wins)
        send_frame(mk3(11, 22, 33), -1, M_NORMAL);
        repeat (3) @(posedge clk);
        pulse_frm(mk3(1, 2, 3), 1'b0);
        @(negedge clk);
        chk("overrun_set", 64'(bus.overrun_o), 64'(1));
        pulse_frm(mk3(4, 5, 6), 1'b1);
        @(negedge clk);
        chk("overrun_set_beats_clr", 64'(bus.overrun_o), 64'(1));
        end_frame(1'b0, 1'b1);

        // Mixer mute on ch1, then a normal frame
        send_frame(mk3(-5, 6, -7), 1, M_MUTE);
        end_frame(1'b1, 1'b0);
        send_frame(mk3(40, 50, 60), -1, M_NORMAL);
        end_frame(1'b0, 1'b0);

        // asynchronous reset while waiting for Q
        fixed_dly = 2;
        send_frame(mk3(123, 45, 67), 0, M_GAPQ);
        n = 0;
        @(negedge clk);
        while (!(bus.mix_valid_i === 1'b1 && bus.mix_last_i === 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached_wait_q", 64'(bus.mix_valid_i), 64'(1));
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("async_reset_outputs", all_outs(), 64'(0));
        exp_out.delete();
        exp_issue.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        fixed_dly = 3;
        send_frame(mk3(-1, 2, -3), -1, M_NORMAL);
        end_frame(1'b0, 1'b0);

        // Q word before I word
        send_frame(mk3(9, 10, 11), 0, M_SWAP);
        end_frame(1'b1, 1'b0);

        // randomized frames with faults, stalls and overruns
        fixed_dly = 0;
        rand_en   = 1'b1;
        for (int t = 0; t < 25; t++) begin
            int  r, fch, fmode;
            bit  inj;
            for (int k = 0; k < NCH; k++) f[k*DW +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
            r     = $urandom_range(0, 9);
            fch   = (r < 7) ? -1 : int'($urandom_range(0, NCH - 1));
            fmode = (r == 9) ? M_SWAP : M_MUTE;
            inj   = ($urandom_range(0, 4) == 0);
            send_frame(f, fch, fmode);
            if (inj) pulse_frm(~f, 1'b0);
            end_frame((fch >= 0), inj);
        end
        rand_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
